// File: rtl/piano_note_tracker_if.sv
// Note-event stream from piano_note_tracker to the tone generator / UART reporter.
// master drives the FIFO head; slave returns evt_ready.
interface piano_note_tracker_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_note;
    logic       evt_on;
    logic [2:0] evt_octave;

    modport master (output evt_valid, evt_note, evt_on, evt_octave, input evt_ready);
    modport slave  (input evt_valid, evt_note, evt_on, evt_octave, output evt_ready);
endinterface

// File: rtl/piano_note_tracker.sv
// PS/2 scan-code tracker for the 12 piano keys: held mask, last note and a show-ahead event FIFO.
// Optional PIANO_OCTAVE_EN adds '-'/'=' octave control; otherwise evt_octave is fixed at 4.
module piano_note_tracker #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 new_key,
    input  logic [7:0]           key_code,
    piano_note_tracker_if.master evt,
    output logic [11:0]          held_mask,
    output logic [3:0]           last_note,
    output logic                 overflow
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    localparam logic [FIFO_AW:0] CNT_ZERO = (FIFO_AW+1)'(0);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    function automatic logic [3:0] note_of(input logic [7:0] code);
        case (code)
            8'h1A:   note_of = 4'd1;
            8'h1B:   note_of = 4'd2;
            8'h22:   note_of = 4'd3;
            8'h23:   note_of = 4'd4;
            8'h21:   note_of = 4'd5;
            8'h2A:   note_of = 4'd6;
            8'h34:   note_of = 4'd7;
            8'h32:   note_of = 4'd8;
            8'h33:   note_of = 4'd9;
            8'h31:   note_of = 4'd10;
            8'h3B:   note_of = 4'd11;
            8'h3A:   note_of = 4'd12;
            default: note_of = 4'd0;
        endcase
    endfunction

    state_t             state_r, state_nxt_s;
    logic               new_key_d_r;
    logic               byte_stb_s;
    logic [3:0]         code_note_s;
    logic [11:0]        note_bit_s;
    logic               note_held_s;
    logic               make_s, brk_s;
    logic               push_req_s, push_s, pop_s;
    logic [2:0]         octave_s;
    logic [7:0]         push_data_s;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_r, wr_ptr_r;
    logic [FIFO_AW:0]   count_r, count_after_pop_s, count_nxt_s;
    logic               evt_valid_r;
    logic [7:0]         head_r, head_nxt_s;
    logic [11:0]        held_mask_r;
    logic [3:0]         last_note_r;
    logic               overflow_r;
`ifdef PIANO_OCTAVE_EN
    logic               oct_up_s, oct_dn_s;
    logic [2:0]         octave_r;
`endif

    assign byte_stb_s  = new_key & ~new_key_d_r;
    assign code_note_s = note_of(key_code);
    assign note_bit_s  = (code_note_s == 4'd0) ? 12'd0 : (12'd1 << (code_note_s - 4'd1));
    assign note_held_s = |(held_mask_r & note_bit_s);

    // Byte edge detector and FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            new_key_d_r <= 1'b0;
            state_r     <= ST_IDLE;
        end else begin
            new_key_d_r <= new_key;
            state_r     <= state_nxt_s;
        end
    end

    // Prefix decoding: classifies each accepted byte as make, break or ignored.
    always_comb begin
        state_nxt_s = state_r;
        make_s      = 1'b0;
        brk_s       = 1'b0;
`ifdef PIANO_OCTAVE_EN
        oct_up_s    = 1'b0;
        oct_dn_s    = 1'b0;
`endif
        if (byte_stb_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (key_code == 8'hF0) begin
                        state_nxt_s = ST_BREAK;
                    end else if (key_code == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else if (code_note_s != 4'd0) begin
                        make_s = 1'b1;
`ifdef PIANO_OCTAVE_EN
                    end else if (key_code == 8'h4E) begin
                        oct_dn_s = 1'b1;
                    end else if (key_code == 8'h55) begin
                        oct_up_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    brk_s       = (code_note_s != 4'd0);
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT: begin
                    state_nxt_s = (key_code == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                ST_EXT_BREAK: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Repeats of a held key and breaks of an unheld key produce no event.
    assign push_req_s  = (make_s & ~note_held_s) | (brk_s & note_held_s);
    assign push_data_s = {code_note_s, make_s, octave_s};
    assign pop_s       = evt_valid_r & evt.evt_ready;
    assign push_s      = push_req_s & ((count_r != CNT_FULL) | pop_s);
    assign count_after_pop_s = count_r - (FIFO_AW+1)'(pop_s);
    assign count_nxt_s       = count_after_pop_s + (FIFO_AW+1)'(push_s);

    // Next head: surviving entry if any, else the entry being pushed, else hold.
    always_comb begin
        head_nxt_s = head_r;
        if (count_after_pop_s != CNT_ZERO) begin
            head_nxt_s = mem_r[rd_ptr_r + FIFO_AW'(pop_s)];
        end else if (push_s) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Held-key mask and most recent still-held note; updates even when the event is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_mask_r <= 12'd0;
            last_note_r <= 4'd0;
        end else if (make_s & ~note_held_s) begin
            held_mask_r <= held_mask_r | note_bit_s;
            last_note_r <= code_note_s;
        end else if (brk_s & note_held_s) begin
            held_mask_r <= held_mask_r & ~note_bit_s;
            if (last_note_r == code_note_s) begin
                last_note_r <= 4'd0;
            end
        end
    end

    // FIFO storage, written without reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r    <= {FIFO_AW{1'b0}};
            wr_ptr_r    <= {FIFO_AW{1'b0}};
            count_r     <= CNT_ZERO;
            evt_valid_r <= 1'b0;
            head_r      <= {4'd0, 1'b0, 3'd4};
            overflow_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            count_r     <= count_nxt_s;
            evt_valid_r <= (count_nxt_s != CNT_ZERO);
            head_r      <= head_nxt_s;
            if (push_req_s & ~push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef PIANO_OCTAVE_EN
    // Octave register, saturating within 1..7.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            octave_r <= 3'd4;
        end else if (oct_up_s && (octave_r != 3'd7)) begin
            octave_r <= octave_r + 3'd1;
        end else if (oct_dn_s && (octave_r != 3'd1)) begin
            octave_r <= octave_r - 3'd1;
        end
    end
    assign octave_s = octave_r;
`else
    assign octave_s = 3'd4;
`endif

    assign evt.evt_valid  = evt_valid_r;
    assign evt.evt_note   = head_r[7:4];
    assign evt.evt_on     = head_r[3];
    assign evt.evt_octave = head_r[2:0];
    assign held_mask      = held_mask_r;
    assign last_note      = last_note_r;
    assign overflow       = overflow_r;
endmodule

// File: tb/tb_piano_note_tracker.sv
// Directed bench for piano_note_tracker: scoreboard model checked every cycle plus literal event checks.
module tb_piano_note_tracker;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        new_key;
    logic [7:0]  key_code;
    logic [11:0] held_mask;
    logic [3:0]  last_note;
    logic        overflow;

    piano_note_tracker_if evt_if ();

    piano_note_tracker #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .new_key   (new_key),
        .key_code  (key_code),
        .evt       (evt_if),
        .held_mask (held_mask),
        .last_note (last_note),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sent_cnt = 0;
    int done_cnt = 0;

    // Model state: key index table, expected event queue, popped-event log taken from the DUT.
    logic [7:0]  piano_codes [12] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
                                      8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A};
    logic [7:0]  exp_q [$];
    logic [7:0]  log_q [$];
    logic [7:0]  last_head;
    logic [11:0] m_held;
    int          m_last;
    bit          m_ovf, m_brk, m_ext;
    int          m_oct;
    bit          prev_valid;
    logic [7:0]  prev_head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int note_for(input logic [7:0] c);
        for (int i = 0; i < 12; i++) begin
            if (piano_codes[i] == c) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [7:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 8'hFF;
    endfunction

    task automatic model_push(input int n, input bit on);
        if (exp_q.size() < DEPTH) exp_q.push_back({4'(n), on, 3'(m_oct)});
        else m_ovf = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        bit is_make, is_break;
        n = note_for(b);
        if (b == 8'hE0 && !m_ext && !m_brk) begin m_ext = 1'b1; return; end
        if (b == 8'hF0 && !m_brk) begin m_brk = 1'b1; return; end
        is_make  = !m_ext && !m_brk;
        is_break = !m_ext && m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
`ifdef PIANO_OCTAVE_EN
        if (is_make && b == 8'h4E && m_oct > 1) m_oct--;
        if (is_make && b == 8'h55 && m_oct < 7) m_oct++;
`endif
        if (n == 0) return;
        if (is_make && !m_held[n-1]) begin
            m_held[n-1] = 1'b1;
            m_last = n;
            model_push(n, 1'b1);
        end else if (is_break && m_held[n-1]) begin
            m_held[n-1] = 1'b0;
            if (m_last == n) m_last = 0;
            model_push(n, 1'b0);
        end
    endtask

    // Model update and comparison, 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!resetn) begin
            exp_q.delete();
            m_held = 12'd0; m_last = 0; m_ovf = 1'b0; m_brk = 1'b0; m_ext = 1'b0; m_oct = 4;
            last_head = {4'd0, 1'b0, 3'd4};
            done_cnt = sent_cnt;
        end else begin
            if (prev_valid && evt_if.evt_ready) log_q.push_back(prev_head);
            if (exp_q.size() != 0 && evt_if.evt_ready) void'(exp_q.pop_front());
            if (new_key && done_cnt != sent_cnt) begin
                model_byte(key_code);
                done_cnt = sent_cnt;
            end
            if (exp_q.size() != 0) last_head = exp_q[0];
            chk("evt_valid",  32'(evt_if.evt_valid),  32'(exp_q.size() != 0));
            chk("evt_note",   32'(evt_if.evt_note),   32'(last_head[7:4]));
            chk("evt_on",     32'(evt_if.evt_on),     32'(last_head[3]));
            chk("evt_octave", 32'(evt_if.evt_octave), 32'(last_head[2:0]));
            chk("held_mask",  32'(held_mask),         32'(m_held));
            chk("last_note",  32'(last_note),         32'(m_last));
            chk("overflow",   32'(overflow),          32'(m_ovf));
        end
        prev_valid = evt_if.evt_valid;
        prev_head  = {evt_if.evt_note, evt_if.evt_on, evt_if.evt_octave};
    end

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        new_key  = 1'b1;
        key_code = b;
        sent_cnt++;
        repeat (hold) @(negedge clk);
        new_key = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; new_key = 1'b0; key_code = 8'h00; evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_valid",  32'(evt_if.evt_valid),  32'd0);
        chk("rst_octave", 32'(evt_if.evt_octave), 32'd4);
        chk("rst_note",   32'(evt_if.evt_note),   32'd0);
        chk("rst_mask",   32'(held_mask),         32'd0);
        chk("rst_last",   32'(last_note),         32'd0);
        chk("rst_ovf",    32'(overflow),          32'd0);

        // Make then break of Z with the consumer always ready.
        evt_if.evt_ready = 1'b1;
        send(8'h1A, 1);
        chk("t1_mask_on", 32'(held_mask), 32'h001);
        chk("t1_last_on", 32'(last_note), 32'd1);
        send(8'hF0, 1);
        send(8'h1A, 2);
        chk("t1_mask_off", 32'(held_mask), 32'h000);
        chk("t1_last_off", 32'(last_note), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_log_n", 32'(log_q.size()), 32'd2);
        chk("t1_log0",  32'(log_at(0)), 32'h1C);
        chk("t1_log1",  32'(log_at(1)), 32'h14);

        // Typematic repeat of G, held-high strobes, then its break.
        log_q.delete();
        for (int i = 0; i < 5; i++) send(8'h34, 1 + (i % 3));
        send(8'hF0, 3);
        send(8'h34, 1);
        repeat (3) @(negedge clk);
        chk("t2_log_n", 32'(log_q.size()), 32'd2);
        chk("t2_log0",  32'(log_at(0)), 32'h7C);
        chk("t2_log1",  32'(log_at(1)), 32'h74);
        chk("t2_ovf",   32'(overflow), 32'd0);

        // Extended and stray-break sequences are ignored.
        log_q.delete();
        send(8'hE0, 1); send(8'h1A, 1);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h1A, 1);
        send(8'hF0, 1); send(8'h3A, 1);
        repeat (3) @(negedge clk);
        chk("t3_log_n", 32'(log_q.size()), 32'd0);
        chk("t3_mask",  32'(held_mask), 32'h000);

        // Five makes against a stalled consumer: fifth event dropped.
        evt_if.evt_ready = 1'b0;
        log_q.delete();
        send(8'h1A, 1); send(8'h1B, 1); send(8'h22, 1); send(8'h23, 1); send(8'h21, 1);
        chk("t4_ovf",   32'(overflow), 32'd1);
        chk("t4_mask",  32'(held_mask), 32'h01F);
        chk("t4_valid", 32'(evt_if.evt_valid), 32'd1);
        evt_if.evt_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_log_n", 32'(log_q.size()), 32'd4);
        chk("t4_log0",  32'(log_at(0)), 32'h1C);
        chk("t4_log1",  32'(log_at(1)), 32'h2C);
        chk("t4_log2",  32'(log_at(2)), 32'h3C);
        chk("t4_log3",  32'(log_at(3)), 32'h4C);
        chk("t4_empty", 32'(evt_if.evt_valid), 32'd0);

        // Full FIFO with a pop and a push in the same cycle.
        reset_pulse();
        evt_if.evt_ready = 1'b0;
        log_q.delete();
        send(8'h1A, 1); send(8'h1B, 1); send(8'h22, 1); send(8'h23, 1);
        @(negedge clk);
        new_key = 1'b1; key_code = 8'h21; sent_cnt++; evt_if.evt_ready = 1'b1;
        @(negedge clk);
        new_key = 1'b0; evt_if.evt_ready = 1'b0;
        chk("t5_ovf",   32'(overflow), 32'd0);
        chk("t5_mask",  32'(held_mask), 32'h01F);
        evt_if.evt_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_log_n", 32'(log_q.size()), 32'd5);
        chk("t5_log0",  32'(log_at(0)), 32'h1C);
        chk("t5_log4",  32'(log_at(4)), 32'h5C);

        // Reset after a lone break prefix discards the prefix.
        reset_pulse();
        log_q.delete();
        send(8'hF0, 1);
        reset_pulse();
        evt_if.evt_ready = 1'b1;
        send(8'h1A, 1);
        repeat (3) @(negedge clk);
        chk("t6_log_n", 32'(log_q.size()), 32'd1);
        chk("t6_log0",  32'(log_at(0)), 32'h1C);
        chk("t6_mask",  32'(held_mask), 32'h001);

`ifdef PIANO_OCTAVE_EN
        // Octave up saturates at 7, down saturates at 1.
        reset_pulse();
        evt_if.evt_ready = 1'b1;
        log_q.delete();
        for (int i = 0; i < 5; i++) send(8'h55, 1);
        send(8'h22, 1);
        repeat (3) @(negedge clk);
        chk("oct_hi_log", 32'(log_at(0)), 32'h3F);
        chk("oct_hi",     32'(evt_if.evt_octave), 32'd7);
        log_q.delete();
        for (int i = 0; i < 8; i++) send(8'h4E, 1);
        send(8'h21, 1);
        repeat (3) @(negedge clk);
        chk("oct_lo_log", 32'(log_at(0)), 32'h59);
        chk("oct_lo",     32'(evt_if.evt_octave), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
